// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 encodings (F3_LB..F3_SW)
//   - LSU state encoding (lsu_state_t)
//   - byte-enable base patterns (BE_BYTE/BE_HALF/BE_WORD)
//   - request legality helpers (illegal funct3, misalignment)
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Loads reject 011/110/111; stores reject anything above SW.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 > F3_SW;
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // funct3[1:0] gives the access size; bytes can never be misaligned.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data alignment: selects the byte/half lane from a RAM
// word and sign- or zero-extends it according to funct3. LW (and any other
// encoding) passes the word through unchanged.
// Ports:
//   i_word   [31:0]  RAM read word
//   i_lane   [1:0]   byte address bits [1:0]
//   i_funct3 [2:0]   load funct3
//   o_data   [31:0]  extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Converts core load/store requests into word-aligned RAM accesses with byte
// enables, extends load data and flags misaligned / illegal requests.
// Optional feature: define LSU_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without mem_ready (response with resp_err = 1).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            core request handshake (ready only in IDLE)
//   req_we, req_funct3             store flag and RV32I funct3
//   req_addr, req_wdata            byte address and store data
//   resp_valid, resp_rdata, resp_err   one-cycle completion pulse + result
//   mem_en, mem_we, mem_be         RAM strobe, write, byte enables
//   mem_addr, mem_wdata            word address, lane-replicated store data
//   mem_rdata, mem_ready           RAM read word, access-complete
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W     = 30,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    lsu_state_t r_state, w_next_state;

    logic                  r_we;
    logic [2:0]            r_f3;
    logic [1:0]            r_lane;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic                  r_err;
    logic [31:0]           r_rdata;

    logic                  w_req_err;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_load_data;
    logic                  w_timeout;

    assign w_req_err = f3_illegal(req_we, req_funct3) ||
                       misaligned(req_funct3, req_addr[1:0]);

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = BE_BYTE << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? (BE_HALF << 2) : BE_HALF;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = BE_WORD;
                w_wdata = req_wdata;
            end
        endcase
    end

    lsu_load_align u_align (
        .i_word   (mem_rdata),
        .i_lane   (r_lane),
        .i_funct3 (r_f3),
        .o_data   (w_load_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [7:0] r_cnt;

    // mem_ready wins over the timeout because the FSM tests it first.
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == ST_IDLE)
            r_cnt <= '0;
        else if (r_state == ST_ACCESS && !mem_ready)
            r_cnt <= r_cnt + 8'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next_state = w_req_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (mem_ready || w_timeout) w_next_state = ST_RESP;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_f3    <= req_funct3;
                    r_lane  <= req_addr[1:0];
                    r_addr  <= req_addr[MEM_ADDR_W+1:2];
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_err   <= w_req_err;
                    r_rdata <= '0;
                end
                ST_ACCESS: begin
                    if (mem_ready)
                        r_rdata <= r_we ? '0 : w_load_data;
                    else if (w_timeout)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from the state register, so an async reset
    // drops mem_en immediately.
    assign req_ready  = (r_state == ST_IDLE);
    assign mem_en     = (r_state == ST_ACCESS);
    assign mem_we     = mem_en & r_we;
    assign mem_be     = mem_en ? r_be : '0;
    assign mem_addr   = mem_en ? r_addr : '0;
    assign mem_wdata  = mem_en ? r_wdata : '0;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = resp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] ram [256];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_ADDR_W(30), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned size_of(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (we ? (f3 > 3'd2) : (f3 inside {3'd3, 3'd6, 3'd7})) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned mask;
        mask = ((1 << size_of(f3)) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        longint v, span;
        int unsigned sz;
        sz   = size_of(f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(word) >> (8 * (a % 4))) & (span - 1);
        if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // One complete request; RAM answers after `waits` wait cycles.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic hold);
        logic        xerr;
        logic [3:0]  xbe;
        logic [31:0] xwd, xrd;
        int          left;
        bit          done;
        xerr = exp_err(we, f3, a);
        xbe  = exp_be(f3, a);
        xwd  = exp_wdata(f3, d);
        xrd  = (we || xerr) ? 32'h0 : exp_load(f3, a, ram[a[9:2]]);
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        if (hold) req_addr = a ^ 32'h40;
        else      req_valid = 1'b0;
        left = waits;
        done = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                done = 1;
                chk("latency", c, xerr ? 1 : waits + 2);
                chk("resp_err", {31'd0, resp_err}, {31'd0, xerr});
                chk("resp_rdata", resp_rdata, xrd);
                chk("en_at_resp", {31'd0, mem_en}, 32'd0);
                last_rd   = resp_rdata;
                req_valid = 1'b0;
                mem_ready = 1'b0;
            end else begin
                chk("en_in_access", {31'd0, mem_en}, {31'd0, !xerr});
                chk("busy_ready", {31'd0, req_ready}, 32'd0);
                if (mem_en) begin
                    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
                    chk("mem_be", {28'd0, mem_be}, {28'd0, xbe});
                    chk("mem_addr", {2'd0, mem_addr}, {2'd0, a[31:2]});
                    if (we) chk("mem_wdata", mem_wdata, xwd);
                end
                mem_rdata = ram[a[9:2]];
                if (left == 0) begin
                    mem_ready = 1'b1;
                    if (we)
                        for (int i = 0; i < 4; i++)
                            if (xbe[i]) ram[a[9:2]][8*i +: 8] = xwd[8*i +: 8];
                end else begin
                    mem_ready = 1'b0;
                    left--;
                end
            end
        end
        if (!done) chk("resp_seen", 32'd0, 32'd1);
        @(negedge clk);
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("back_idle", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra;
        int unsigned sz;

        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0; last_rd = '0;
        #22;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_en", {31'd0, mem_en}, 32'd0);
        chk("rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;

        // SW / SB / LB / LBU / LH
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1'b0);
        chk("sw_ram", ram[8'h40], 32'hDEADBEEF);
        do_req(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 1'b0);
        chk("sb_ram", ram[8'h80], 32'hA5000000);
        do_req(1'b0, 3'b000, 32'h203, 32'h0, 0, 1'b0);
        chk("lb_const", last_rd, 32'hFFFFFFA5);
        do_req(1'b0, 3'b100, 32'h203, 32'h0, 0, 1'b0);
        chk("lbu_const", last_rd, 32'h000000A5);
        ram[8'h40] = 32'h80011234;
        do_req(1'b0, 3'b001, 32'h102, 32'h0, 0, 1'b0);
        chk("lh_const", last_rd, 32'hFFFF8001);
        do_req(1'b0, 3'b001, 32'h101, 32'h0, 0, 1'b0);   // misaligned half
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0);   // illegal load funct3
        do_req(1'b1, 3'b100, 32'h100, 32'h0, 0, 1'b0);   // illegal store funct3
        do_req(1'b0, 3'b010, 32'h102, 32'h0, 0, 1'b0);   // misaligned word
        // LW with 3 wait states, competing request held during the wait
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b1);

        // reset during ACCESS
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        mem_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_en", {31'd0, mem_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en_drop", {31'd0, mem_en}, 32'd0);
        chk("async_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resp_in_rst", {31'd0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1, 1'b0);

        // stall with mem_ready low
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        mem_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("to_resp", {31'd0, resp_valid}, {31'd0, c == 5});
            if (c == 5) begin
                chk("to_err", {31'd0, resp_err}, 32'd1);
                chk("to_rdata", resp_rdata, 32'd0);
            end
        end
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c % 10 == 0) begin
                chk("stall_en", {31'd0, mem_en}, 32'd1);
                chk("stall_noresp", {31'd0, resp_valid}, 32'd0);
            end
        end
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
`endif

        // random traffic
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        for (int n = 0; n < 80; n++) begin
            rwe = 1'($urandom % 2);
            rf3 = 3'($urandom % 8);
            ra  = $urandom % 1024;
            sz  = size_of(rf3);
            if (($urandom % 4) != 0 && sz <= 4) ra = ra & ~(sz - 1);
            do_req(rwe, rf3, ra, $urandom, int'($urandom % 4), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the core's data-memory port, between the core and a 32-bit word-organised data RAM.
- Converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW, selected by funct3) into word-aligned RAM accesses with byte enables.
- Shifts, sign- or zero-extends load data, and flags misaligned accesses.
- Supports RAMs with variable wait states via a ready handshake.

Parameters:
- MEM_ADDR_W, 30, word-address width presented to the RAM.
- TIMEOUT_CYCLES, 16, cycles waited for mem_ready before aborting (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request (IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store
- req_addr  in  32  byte address (rs1 + imm)
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load result, 0 for stores
- resp_err  out  1  valid with resp_valid: misaligned / illegal funct3 / timeout
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  MEM_ADDR_W  word address = req_addr[MEM_ADDR_W+1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  RAM read word
- mem_ready  in  1  RAM completes access this cycle

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 except req_ready = 1. Reset mid-access drops the access immediately, and no response is issued.
- States: IDLE, ACCESS, RESP.
  - IDLE: req_ready = 1. On req_valid, latch request. If misaligned or funct3 illegal, go to RESP with err = 1 and assert no mem_en. Otherwise go to ACCESS.
  - ACCESS: mem_en = 1 with mem_we, mem_be, mem_addr, mem_wdata held stable from latched values. On mem_ready, capture mem_rdata and go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready = 0 in ACCESS and RESP.
- Latency: 2 cycles from request accept to resp_valid with zero-wait RAM (mem_ready high in first ACCESS cycle); +1 per wait cycle. Error responses: 1 cycle.
- Little-endian. Lane = addr[1:0].
  - Byte: be = 1 << lane; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 (lane 0) or 1100 (lane 2); wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
- Misaligned: half with addr[0] = 1; word with addr[1:0] != 0. Byte accesses are never misaligned.
- Illegal funct3:
  - load: 011, 110, 111
  - store: any value above 010
- Load extension:
  - LB/LH sign-extend the selected byte/half.
  - LBU/LHU zero-extend.
  - LW passes the word.
- Stores return resp_rdata = 0. Errored responses return rdata = 0 and assert no RAM strobe.
- req_valid is ignored outside IDLE; the core must hold the request until it is accepted.
- mem_ready outside ACCESS is ignored.
- Back-to-back: a new request is accepted in the IDLE cycle following RESP; no pipelining.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready. On reaching TIMEOUT_CYCLES, drop mem_en and go to RESP with resp_err = 1 and rdata = 0. A mem_ready in the same cycle the count is reached takes priority (normal completion).
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package/header (alongside opcodes.vh):
  - funct3 load/store encodings (F3_LB..F3_SW)
  - LSU state encodings
  - byte-enable constants BE_BYTE/BE_HALF/BE_WORD
- One natural combinational sub-module: lsu_load_align (lane select + sign/zero extend, inputs word, addr[1:0], funct3). Reused by a future instruction-side compressed fetch.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, zero-wait RAM -> mem_addr 0x40, be 1111, wdata 0xDEADBEEF; resp_valid 2 cycles after accept, err 0.
- SB addr 0x203, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5. Then LB addr 0x203 with RAM word 0xA5000000 -> rdata 0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr 0x102, RAM 0x8001_1234 -> rdata 0xFFFF8001. LH addr 0x101 -> resp_err 1 one cycle after accept, mem_en never asserted.
- LW with mem_ready delayed 3 cycles -> mem outputs stable throughout, resp_valid on the 5th cycle after accept. A second req_valid during the wait is not accepted.
- rst_n pulled low during ACCESS -> mem_en falls asynchronously, no resp_valid. After release, req_ready = 1 and the next request completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4: mem_ready held low -> resp_err 1 after 4 ACCESS cycles. Without the macro, the unit stays in ACCESS for 100 cycles.
